// File: rtl/booth_divider_iter_pkg.sv
// rtl/booth_divider_iter_pkg.sv - shared types and operand conventions for the iterative divider
package booth_divider_iter_pkg;

  // Datapath width shared with the Booth/Wallace multiplier in the execute stage.
  localparam int DEF_WIDTH = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Extension bit placed above a W-bit operand: the sign bit for signed ops, zero for unsigned.
  function automatic logic ext_bit(input logic is_signed, input logic msb);
    return is_signed & msb;
  endfunction

endpackage

// File: rtl/booth_divider_iter_if.sv
// rtl/booth_divider_iter_if.sv - operand/result handshake bundle for the iterative divider
interface booth_divider_iter_if import booth_divider_iter_pkg::*; #(
  parameter int W = DEF_WIDTH
) ();

  logic [W:0]   src1;
  logic [W:0]   src2;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  // Issuing side: presents operands and consumes results.
  modport master (
    output src1, src2, in_valid, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  // Divider side.
  modport slave (
    input  src1, src2, in_valid, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/booth_divider_iter_div_restore_step.sv
// rtl/booth_divider_iter_div_restore_step.sv - one combinational restoring-division iteration
module div_restore_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic       fits;

  // Shift the next dividend bit into the partial remainder and subtract when the divisor fits.
  // The partial remainder is always below the divisor, so the shifted value needs W+1 bits for
  // the compare while the restored or subtracted result always fits back into W bits.
  always_comb begin
    shifted  = {rem, quo[W-1]};
    fits     = (shifted >= {1'b0, dvs});
    rem_next = shifted[W-1:0];
    quo_next = {quo[W-2:0], 1'b0};
    if (fits) begin
      rem_next = shifted[W-1:0] - dvs;
      quo_next = {quo[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/booth_divider_iter.sv
// rtl/booth_divider_iter.sv - iterative radix-2 restoring divider with quotient/remainder sign fix-up
module booth_divider_iter import booth_divider_iter_pkg::*; #(
  parameter int COMPUTER_WIDTH = DEF_WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  booth_divider_iter_if.slave bus
);

  localparam int W     = COMPUTER_WIDTH;
  localparam int CNT_W = $clog2(W);

  state_t           state;
  state_t           state_next;
  logic             primed;
  logic [CNT_W-1:0] cnt;
  logic             sign1;
  logic             sign2;
  logic             zero_flag;
  logic [W-1:0]     dvd_raw;
  logic [W-1:0]     dvs_mag;
  logic [W-1:0]     rem_part;
  logic [W-1:0]     quo_part;
  logic [W-1:0]     quo_reg;
  logic [W-1:0]     rem_reg;
  logic             dz_reg;
  logic [W-1:0]     step_rem;
  logic [W-1:0]     step_quo;
  logic [W-1:0]     mag1;
  logic [W-1:0]     mag2;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;

  // Magnitudes of the extended operands; |-2^(W-1)| wraps to 2^(W-1), which still fits unsigned.
  always_comb begin
    mag1 = bus.src1[W-1:0];
    mag2 = bus.src2[W-1:0];
    if (bus.src1[W]) mag1 = ~bus.src1[W-1:0] + 1'b1;
    if (bus.src2[W]) mag2 = ~bus.src2[W-1:0] + 1'b1;
  end

  div_restore_step #(.W(W)) u_step (
    .rem      (rem_part),
    .quo      (quo_part),
    .dvs      (dvs_mag),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // State register; primed holds in_ready low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      primed <= 1'b0;
    end else begin
      state  <= state_next;
      primed <= 1'b1;
    end
  end

  // Next-state logic: W iterations in BUSY, one fix-up cycle, then hold until the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (cnt == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: ready only when idle and primed, result valid only in DONE.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      ST_IDLE: in_ready_c  = primed;
      ST_DONE: out_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign accept        = in_ready_c & bus.in_valid;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.quotient  = quo_reg;
  assign bus.remainder = rem_reg;
  assign bus.div_zero  = dz_reg;

  // Operand latch, iteration and sign fix-up; results stay frozen while DONE waits for out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      zero_flag <= 1'b0;
      dvd_raw   <= '0;
      dvs_mag   <= '0;
      rem_part  <= '0;
      quo_part  <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sign1     <= bus.src1[W];
            sign2     <= bus.src2[W];
            zero_flag <= (bus.src2 == '0);
            dvd_raw   <= bus.src1[W-1:0];
            dvs_mag   <= mag2;
            rem_part  <= '0;
            quo_part  <= mag1;
            cnt       <= CNT_W'(W - 1);
          end
        end
        ST_BUSY: begin
          rem_part <= step_rem;
          quo_part <= step_quo;
          cnt      <= cnt - 1'b1;
        end
        ST_FIX: begin
          dz_reg <= zero_flag;
          if (zero_flag) begin
            quo_reg <= '1;
            rem_reg <= dvd_raw;
          end else begin
            quo_reg <= (sign1 ^ sign2) ? (~quo_part + 1'b1) : quo_part;
            rem_reg <= sign1 ? (~rem_part + 1'b1) : rem_part;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_iter.sv
// tb/tb_booth_divider_iter.sv - self-checking bench for the iterative divider
module tb_booth_divider_iter;
  import booth_divider_iter_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W:0]   s1;
    logic [W:0]   s2;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  booth_divider_iter_if #(.W(W)) bus ();

  booth_divider_iter #(.COMPUTER_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Waits for in_ready (bounded), presents operands for exactly the accept edge, returns #1 after it.
  task automatic start_op(input logic [W:0] a, input logic [W:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", (n < 60), 1'b1);
    bus.src1     = a;
    bus.src2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.src1     = ~a;
    bus.src2     = ~b;
  endtask

  // Counts edges after the accept edge until out_valid is seen (sampled at negedge).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  vec_t vecs[14];

  initial begin
    int           lat;
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    logic         stable;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         sg;

    vecs[0]  = '{33'h0_00000064, 33'h0_00000007, 32'h0000000E, 32'h00000002, 1'b0};
    vecs[1]  = '{33'h1_FFFFFFF9, 33'h0_00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{33'h0_00000007, 33'h1_FFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0};
    vecs[3]  = '{33'h1_FFFFFFF0, 33'h0_00000000, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1};
    vecs[4]  = '{33'h1_80000000, 33'h1_FFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[5]  = '{33'h0_FFFFFFFF, 33'h0_00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[6]  = '{33'h0_FFFFFFFF, 33'h0_00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0};
    vecs[7]  = '{33'h1_FFFFFF9C, 33'h1_FFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0};
    vecs[8]  = '{33'h0_00000000, 33'h0_00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{33'h0_00000003, 33'h0_00000005, 32'h00000000, 32'h00000003, 1'b0};
    vecs[10] = '{33'h0_80000000, 33'h0_00000003, 32'h2AAAAAAA, 32'h00000002, 1'b0};
    vecs[11] = '{33'h1_80000000, 33'h0_00000001, 32'h80000000, 32'h00000000, 1'b0};
    vecs[12] = '{33'h0_00000005, 33'h0_00000000, 32'hFFFFFFFF, 32'h00000005, 1'b1};
    vecs[13] = '{33'h0_7FFFFFFF, 33'h1_FFFFFFFF, 32'h80000001, 32'h00000000, 1'b0};

    bus.src1      = '0;
    bus.src2      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;

    // Reset state, then in_ready rises on the first edge without reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_outputs", {bus.quotient, bus.remainder, bus.div_zero}, '0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_in_ready", bus.in_ready, 1'b1);

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].s1, vecs[i].s2);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), lat, 33);
      check($sformatf("v%0d_quotient", i), bus.quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), bus.remainder, vecs[i].r);
      check($sformatf("v%0d_div_zero", i), bus.div_zero, vecs[i].dz);
      check($sformatf("v%0d_no_ready_with_valid", i), bus.in_ready, 1'b0);
      take_result();
      check($sformatf("v%0d_release", i), {bus.out_valid, bus.in_ready}, 2'b01);
    end

    // Back-pressure: results frozen, in_ready low, stray in_valid ignored.
    start_op(33'h0_00000064, 33'h0_00000007);
    wait_result(lat);
    q0 = bus.quotient;
    r0 = bus.remainder;
    check("bp_first_q", q0, 32'h0000000E);
    stable       = 1'b1;
    bus.src1     = 33'h0_00000009;
    bus.src2     = 33'h0_00000003;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.quotient !== q0 || bus.remainder !== r0)
        stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("bp_hold_stable", stable, 1'b1);
    check("bp_hold_r", bus.remainder, 32'h00000002);
    take_result();
    check("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);

    // Reset in the middle of an operation aborts it.
    start_op(33'h0_00001000, 33'h0_00000003);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_flags", {bus.in_ready, bus.out_valid}, 2'b00);
    reset = 1'b0;
    start_op(33'h1_FFFFFFF9, 33'h0_00000002);
    wait_result(lat);
    check("midrst_latency", lat, 33);
    check("midrst_result", {bus.quotient, bus.remainder}, {32'hFFFFFFFD, 32'hFFFFFFFF});
    take_result();

    // Random signed/unsigned operations against a behavioural reference.
    for (int i = 0; i < 120; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = pick_val();
      b  = pick_val();
      if (b == '0) begin
        eq  = '1;
        er  = a;
        edz = 1'b1;
      end else begin
        edz = 1'b0;
        if (sg) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000;
            er = '0;
          end else begin
            eq = $signed(a) / $signed(b);
            er = $signed(a) % $signed(b);
          end
        end else begin
          eq = a / b;
          er = a % b;
        end
      end
      start_op({ext_bit(sg, a[W-1]), a}, {ext_bit(sg, b[W-1]), b});
      wait_result(lat);
      check($sformatf("rnd%0d s=%0d %h/%h", i, sg, a, b),
            {lat[7:0], bus.quotient, bus.remainder, bus.div_zero},
            {8'd33, eq, er, edz});
      take_result();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
